// File: rtl/noc_pkg.sv
// Shared definitions for the NoC configure-word injector and the mesh decoder.
package noc_pkg;

    localparam int unsigned CFG_W     = 11;
    localparam int unsigned NODE_W    = 2;
    localparam int unsigned LEN_W     = 8;
    localparam int unsigned CNT8_W    = 8;

    // Field placement inside the configure word.
    localparam int unsigned VALID_BIT = 0;
    localparam int unsigned DEST_LSB  = 1;
    localparam int unsigned LEN_LSB   = 3;

    // Injector FSM encoding.
    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_LOAD    = 3'd1;
    localparam logic [ST_W-1:0] ST_DRIVE   = 3'd2;
    localparam logic [ST_W-1:0] ST_RELEASE = 3'd3;
    localparam logic [ST_W-1:0] ST_GAP     = 3'd4;

    // Request payload as queued in the FIFO.
    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [NODE_W-1:0] dest;
    } req_t;

    // Build a valid configure word from a request.
    function automatic logic [CFG_W-1:0] pack_cfg(input req_t r);
        logic [CFG_W-1:0] w;
        w                       = '0;
        w[VALID_BIT]            = 1'b1;
        w[DEST_LSB +: NODE_W]   = r.dest;
        w[LEN_LSB +: LEN_W]     = r.len;
        return w;
    endfunction

    // Saturating 8-bit increment.
    function automatic logic [CNT8_W-1:0] sat_inc(input logic [CNT8_W-1:0] v);
        return (v == '1) ? v : v + CNT8_W'(1);
    endfunction

endpackage

// File: rtl/noc_config_injector_if.sv
// Processor request / mesh configure bundle for one injector instance.
interface noc_config_injector_if #(
    parameter int unsigned DEPTH = 4
);
    import noc_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              req_valid;
    logic              req_ready;
    logic [NODE_W-1:0] req_dest;
    logic [LEN_W-1:0]  req_len;
    logic [CFG_W-1:0]  configure_out;
    logic              proc_ready;
    logic              done_pulse;
    logic              timeout_pulse;
    logic              err_pulse;
    logic              busy;
    logic [CNT_W-1:0]  fifo_count;

    // Processor and mesh side.
    modport master (
        output req_valid, req_dest, req_len, proc_ready,
        input  req_ready, configure_out, done_pulse, timeout_pulse, err_pulse, busy, fifo_count
    );

    // Injector side.
    modport slave (
        input  req_valid, req_dest, req_len, proc_ready,
        output req_ready, configure_out, done_pulse, timeout_pulse, err_pulse, busy, fifo_count
    );

endinterface

// File: rtl/noc_req_fifo.sv
// Synchronous request FIFO with async active-low clear and registered ready.
module noc_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_data,
    output logic                   o_ready,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ready;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    assign w_push      = i_push & r_ready;
    assign w_pop       = i_pop & (r_count != '0);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    assign o_data  = r_mem[r_rd_ptr];
    assign o_ready = r_ready;
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Storage write; no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and ready; ready stays low while cleared.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != CW'(DEPTH));
        end
    end

endmodule

// File: rtl/noc_config_injector.sv
// Per-processor injector: queues route requests and drives them one at a time
// onto the mesh configure input, holding each until the mesh reports ready.
module noc_config_injector
    import noc_pkg::*;
#(
    parameter int unsigned NODE_ID    = 0,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned HOLD_MIN   = 2,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    noc_config_injector_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ST_W-1:0]   r_state,    w_state_nxt;
    logic [CFG_W-1:0]  r_cfg,      w_cfg_nxt;
    logic [CNT8_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic [CNT8_W-1:0] r_to_cnt,   w_to_cnt_nxt;
    logic [CNT8_W-1:0] r_gap_cnt,  w_gap_cnt_nxt;
    logic              r_sticky,   w_sticky_nxt;
    logic              r_done,     w_done_nxt;
    logic              r_timeout,  w_timeout_nxt;
    logic              r_err,      w_err_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              w_seen;
    logic              w_pop;
    logic              w_empty;
    logic              w_fifo_ready;
    logic [CNT_W-1:0]  w_count;
    req_t              w_req;
    req_t              w_head;

    assign w_req = '{len: bus.req_len, dest: bus.req_dest};

    noc_req_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(req_t))
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (bus.req_valid),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_ready (w_fifo_ready),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.req_ready     = w_fifo_ready;
    assign bus.fifo_count    = w_count;
    assign bus.configure_out = r_cfg;
    assign bus.done_pulse    = r_done;
    assign bus.timeout_pulse = r_timeout;
    assign bus.err_pulse     = r_err;
    assign bus.busy          = r_busy;

    // Next-state, next-word and event decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_cfg_nxt      = r_cfg;
        w_hold_cnt_nxt = r_hold_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_sticky_nxt   = r_sticky;
        w_done_nxt     = 1'b0;
        w_timeout_nxt  = 1'b0;
        w_err_nxt      = 1'b0;
        w_pop          = 1'b0;
        w_seen         = r_sticky | bus.proc_ready;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_pop = 1'b1;
                if (w_head.dest == NODE_W'(NODE_ID)) begin
                    // Self-destined request is dropped without touching the mesh.
                    w_err_nxt     = 1'b1;
                    w_cfg_nxt     = '0;
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = ST_GAP;
                end else begin
                    // Counters count the DRIVE cycle about to start.
                    w_cfg_nxt      = pack_cfg(w_head);
                    w_hold_cnt_nxt = CNT8_W'(1);
                    w_to_cnt_nxt   = CNT8_W'(1);
                    w_sticky_nxt   = 1'b0;
                    w_state_nxt    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                w_sticky_nxt   = w_seen;
                w_hold_cnt_nxt = sat_inc(r_hold_cnt);
                w_to_cnt_nxt   = sat_inc(r_to_cnt);
                if (w_seen && (r_hold_cnt >= CNT8_W'(HOLD_MIN))) begin
                    w_cfg_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end else if (!w_seen && (r_to_cnt >= CNT8_W'(TIMEOUT))) begin
                    w_cfg_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = ST_GAP;
                end
            end
            ST_RELEASE: begin
                w_gap_cnt_nxt = '0;
                w_state_nxt   = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap_cnt >= CNT8_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = sat_inc(r_gap_cnt);
                end
            end
            default: begin
                w_cfg_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State, configure word, counters and event pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cfg      <= '0;
            r_hold_cnt <= '0;
            r_to_cnt   <= '0;
            r_gap_cnt  <= '0;
            r_sticky   <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cfg      <= w_cfg_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_sticky   <= w_sticky_nxt;
            r_done     <= w_done_nxt;
            r_timeout  <= w_timeout_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_noc_config_injector.sv
// Directed, table-driven bench for noc_config_injector.
module tb_noc_config_injector;
    import noc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errs   = 0;

    noc_config_injector_if #(.DEPTH(4)) bus0 ();
    noc_config_injector_if #(.DEPTH(4)) bus2 ();

    noc_config_injector #(
        .NODE_ID(0), .DEPTH(4), .HOLD_MIN(2), .GAP_CYCLES(2), .TIMEOUT(255)
    ) dut0 (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus0)
    );

    noc_config_injector #(
        .NODE_ID(2), .DEPTH(4), .HOLD_MIN(2), .GAP_CYCLES(2), .TIMEOUT(255)
    ) dut2 (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dest;
        logic [7:0]  len;
        int          rdy_d;      // ready goes high once this many word cycles have passed
        logic [10:0] exp_cfg;
        int          exp_drive;  // cycles the word is visible
        int          exp_done;
        int          exp_to;
        int          exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push0(input logic [1:0] dest, input logic [7:0] len);
        bus0.req_dest  = dest;
        bus0.req_len   = len;
        bus0.req_valid = 1'b1;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
    endtask

    // One request through dut0 from an idle, empty injector.
    task automatic run_one(input int idx, input vec_t v);
        int          k;
        int          pulse_cyc;
        int          n_done, n_to, n_err, n_bad;
        logic [10:0] cyc1_cfg, cyc2_cfg;
        bit          finished;
        k = 0; pulse_cyc = -1; n_done = 0; n_to = 0; n_err = 0; n_bad = 0;
        cyc1_cfg = 'x; cyc2_cfg = 'x; finished = 1'b0;
        bus0.proc_ready = 1'b0;
        push0(v.dest, v.len);
        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) cyc1_cfg = bus0.configure_out;
            if (cyc == 2) cyc2_cfg = bus0.configure_out;
            if (bus0.configure_out[0]) begin
                k++;
                if (bus0.configure_out != v.exp_cfg) n_bad++;
            end else if (bus0.configure_out != '0) begin
                n_bad++;
            end
            bus0.proc_ready = bus0.configure_out[0] && (k > v.rdy_d);
            if (bus0.done_pulse)    n_done++;
            if (bus0.timeout_pulse) n_to++;
            if (bus0.err_pulse)     n_err++;
            if (pulse_cyc < 0 && (bus0.done_pulse || bus0.timeout_pulse || bus0.err_pulse))
                pulse_cyc = cyc;
            if (pulse_cyc > 0 && !bus0.busy) finished = 1'b1;
        end
        bus0.proc_ready = 1'b0;
        chk($sformatf("v%0d finished", idx), 32'(finished), 32'd1);
        chk($sformatf("v%0d cfg_cyc1", idx), 32'(cyc1_cfg), 32'd0);
        chk($sformatf("v%0d cfg_cyc2", idx), 32'(cyc2_cfg), 32'(v.exp_cfg));
        chk($sformatf("v%0d word_stable", idx), 32'(n_bad), 32'd0);
        chk($sformatf("v%0d drive_cycles", idx), 32'(k), 32'(v.exp_drive));
        chk($sformatf("v%0d done_cnt", idx), 32'(n_done), 32'(v.exp_done));
        chk($sformatf("v%0d timeout_cnt", idx), 32'(n_to), 32'(v.exp_to));
        chk($sformatf("v%0d err_cnt", idx), 32'(n_err), 32'(v.exp_err));
        chk($sformatf("v%0d pulse_cyc", idx), 32'(pulse_cyc), 32'(v.exp_drive + 2));
    endtask

    // Four back-to-back requests queued behind an occupying request.
    task automatic run_burst();
        logic [10:0] exp_w [5];
        logic [1:0]  b_dest [4];
        logic [7:0]  b_len  [4];
        int          idx, zrun, n_done;
        bit          prev_v, finished;
        exp_w[0] = 11'h083; exp_w[1] = 11'h10D; exp_w[2] = 11'h217;
        exp_w[3] = 11'h423; exp_w[4] = 11'h645;
        b_dest[0] = 2'd2; b_len[0] = 8'h21;
        b_dest[1] = 2'd3; b_len[1] = 8'h42;
        b_dest[2] = 2'd1; b_len[2] = 8'h84;
        b_dest[3] = 2'd2; b_len[3] = 8'hC8;
        bus0.proc_ready = 1'b0;
        push0(2'd1, 8'h10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("burst first_word", 32'(bus0.configure_out), 32'(exp_w[0]));
        for (int i = 0; i < 4; i++) push0(b_dest[i], b_len[i]);
        chk("burst fifo_count_full", 32'(bus0.fifo_count), 32'd4);
        chk("burst req_ready_full", 32'(bus0.req_ready), 32'd0);
        chk("burst word_held", 32'(bus0.configure_out), 32'(exp_w[0]));
        push0(2'd3, 8'hEE);
        chk("burst push_while_full", 32'(bus0.fifo_count), 32'd4);
        idx = 1; zrun = 0; n_done = 0; prev_v = 1'b1; finished = 1'b0;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            @(posedge clk); #1;
            if (bus0.configure_out[0] && !prev_v) begin
                if (idx < 5) chk($sformatf("burst word%0d", idx), 32'(bus0.configure_out), 32'(exp_w[idx]));
                else         chk("burst extra_word", 32'(bus0.configure_out), 32'd0);
                chk($sformatf("burst gap%0d", idx), 32'(zrun >= 3), 32'd1);
                idx++;
                zrun = 0;
            end
            if (!bus0.configure_out[0]) zrun++;
            prev_v = bus0.configure_out[0];
            bus0.proc_ready = bus0.configure_out[0];
            if (bus0.done_pulse) n_done++;
            if (n_done >= 5 && !bus0.busy) finished = 1'b1;
        end
        bus0.proc_ready = 1'b0;
        chk("burst words_seen", 32'(idx), 32'd5);
        chk("burst done_cnt", 32'(n_done), 32'd5);
        chk("burst fifo_empty", 32'(bus0.fifo_count), 32'd0);
        chk("burst req_ready_after", 32'(bus0.req_ready), 32'd1);
    endtask

    // Reset dropped mid-DRIVE with two requests still queued.
    task automatic run_reset();
        int n_nz;
        bus0.proc_ready = 1'b0;
        push0(2'd1, 8'h05);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst word_before", 32'(bus0.configure_out), 32'h02B);
        push0(2'd2, 8'h11);
        push0(2'd3, 8'h22);
        chk("rst queued", 32'(bus0.fifo_count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst cfg_async", 32'(bus0.configure_out), 32'd0);
        chk("rst fifo_count", 32'(bus0.fifo_count), 32'd0);
        chk("rst busy", 32'(bus0.busy), 32'd0);
        chk("rst req_ready", 32'(bus0.req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        n_nz = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus0.configure_out != '0) n_nz++;
        end
        chk("rst no_stale_word", 32'(n_nz), 32'd0);
        chk("rst fifo_after", 32'(bus0.fifo_count), 32'd0);
        chk("rst busy_after", 32'(bus0.busy), 32'd0);
        chk("rst req_ready_after", 32'(bus0.req_ready), 32'd1);
    endtask

    // Self-destined request on the NODE_ID=2 instance.
    task automatic run_self_dest();
        int n_nz, n_err, n_done, n_to;
        n_nz = 0; n_err = 0; n_done = 0; n_to = 0;
        bus2.proc_ready = 1'b1;
        bus2.req_dest   = 2'd2;
        bus2.req_len    = 8'h55;
        bus2.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus2.configure_out != '0) n_nz++;
            if (bus2.err_pulse)     n_err++;
            if (bus2.done_pulse)    n_done++;
            if (bus2.timeout_pulse) n_to++;
        end
        bus2.proc_ready = 1'b0;
        chk("self cfg_never", 32'(n_nz), 32'd0);
        chk("self err_cnt", 32'(n_err), 32'd1);
        chk("self done_cnt", 32'(n_done), 32'd0);
        chk("self timeout_cnt", 32'(n_to), 32'd0);
        chk("self fifo_empty", 32'(bus2.fifo_count), 32'd0);
        chk("self busy", 32'(bus2.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ev;
        vecs[0] = '{2'd1, 8'h01,   6, 11'h00B,   7, 1, 0, 0};
        vecs[1] = '{2'd2, 8'hA5,   0, 11'h52D,   2, 1, 0, 0};
        vecs[2] = '{2'd3, 8'hFF,   1, 11'h7FF,   2, 1, 0, 0};
        vecs[3] = '{2'd1, 8'h80,   3, 11'h403,   4, 1, 0, 0};
        vecs[4] = '{2'd0, 8'h77,   0, 11'h000,   0, 0, 0, 1};
        vecs[5] = '{2'd2, 8'h3C, 255, 11'h1E5, 255, 0, 1, 0};
        vecs[6] = '{2'd3, 8'h00,   2, 11'h007,   3, 1, 0, 0};

        rst_n = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_dest = '0; bus0.req_len = '0; bus0.proc_ready = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_dest = '0; bus2.req_len = '0; bus2.proc_ready = 1'b0;
        #2;
        chk("reset cfg", 32'(bus0.configure_out), 32'd0);
        chk("reset req_ready", 32'(bus0.req_ready), 32'd0);
        chk("reset busy", 32'(bus0.busy), 32'd0);
        chk("reset fifo_count", 32'(bus0.fifo_count), 32'd0);
        chk("reset pulses", 32'({bus0.done_pulse, bus0.timeout_pulse, bus0.err_pulse}), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset req_ready", 32'(bus0.req_ready), 32'd1);

        // Ready while idle must have no effect.
        bus0.proc_ready = 1'b1;
        n_ev = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus0.done_pulse || bus0.busy || bus0.configure_out != '0) n_ev++;
        end
        bus0.proc_ready = 1'b0;
        chk("idle ready_ignored", 32'(n_ev), 32'd0);

        for (int i = 0; i < 7; i++) run_one(i, vecs[i]);
        run_burst();
        run_self_dest();
        run_reset();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
